aes_reg_ctrl: RTL and testbench
===============================

# aes_reg_ctrl

Controller and arbiter for the AES block's 16-word × 32-bit register bank with per-byte lane enables. Two write requesters share the bank: the host bus, an Avalon-MM-style slave with waitrequest, and the AES core's result writeback. The block also sequences a run: host start command, core busy, done status. It sits between the bus interconnect and the AES core and presents key and message words to the core as flat vectors.

## Interface
Parameters:
- NWORDS, 16, number of 32-bit words in the bank (address width fixed at 4)
- STALL_MAX, 1, consecutive cycles the core may be denied before it gets priority

Ports:
- Clk  in  1  clock
- Reset_n  in  1  asynchronous, active-low reset
- avl_cs  in  1  host chip select
- avl_read  in  1  host read strobe
- avl_write  in  1  host write strobe
- avl_addr  in  4  host word address
- avl_byte_en  in  4  host byte lane enables; bit i enables Din[8i+7:8i]
- avl_writedata  in  32  host write data
- avl_readdata  out  32  registered read data
- avl_waitrequest  out  1  host write stalled this cycle
- core_req  in  1  core write request; held until granted
- core_addr  in  4  core word address (legal: 8–11, 15)
- core_be  in  4  core byte enables
- core_wdata  in  32  core write data
- core_gnt  out  1  core write accepted this cycle
- core_done  in  1  one-cycle pulse: result fully written
- aes_start  out  1  one-cycle start pulse to core
- aes_key  out  128  words 0–3, word 0 in [127:96]
- aes_msg  out  128  words 4–7, word 4 in [127:96]

## Operation
- Map: 0–3 key; 4–7 message; 8–11 ciphertext; 12–13 scratch; 14 command (write-only, reads 0); 15 status (read-only to host: bit0 DONE, bit1 BUSY, rest 0).
- Byte lanes: any 4-bit mask is legal; 0000 is a no-op.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: accepted host write to 14 with byte_en[0]=1 and data[0]=1.
  - BUSY → DONE: core_done=1.
  - DONE → BUSY: start command (restart).
  - DONE → IDLE: host write to 14 with byte_en[0]=1 and data[0]=0.
  - A start command in BUSY is ignored.
  - core_done outside BUSY is ignored.
- While BUSY, host writes to 0–11 complete (no waitrequest) but are dropped.
- Core writes:
  - Accepted only to 8–11 and 15, where a core write to 15 is ignored.
  - Writes to illegal addresses are granted and dropped.
- Arbitration, when a host write (avl_cs & avl_write) and core_req occur in the same cycle:
  - Host wins: core_gnt=0, deny counter increments.
  - Once the deny counter reaches STALL_MAX, core wins: core_gnt=1, avl_waitrequest=1, and the host holds its signals.
  - The deny counter clears on any core grant.
- With no conflict, both are granted immediately. avl_waitrequest is 0 otherwise.
- Host reads are not arbitrated. A same-cycle core write to the read address returns the old value.

## Timing
- Reset (async assert, sync release): all words 0, state IDLE, avl_readdata 0, aes_start 0, core_gnt 0, avl_waitrequest 0, deny counter 0.
- Reset mid-run aborts silently. No done is reported.
- Writes: data visible in the bank and on aes_key/aes_msg the cycle after acceptance.
- Read latency: 1 cycle. avl_readdata is updated on avl_cs & avl_read and holds its value otherwise.
- aes_start asserts the cycle after start acceptance, for exactly 1 cycle. BUSY reads 1 the same cycle.
- Status DONE is readable 1 cycle after core_done.
- core_gnt and avl_waitrequest are combinational from the current request and the deny counter.

## Configuration
- AES_KEY_READBACK_EN:
  - Defined: host reads of words 0–3 return the stored key.
  - Undefined: those reads return 32'h0. Writes and aes_key are unaffected.

## Structure
- Package aes_reg_pkg holds:
  - address constants (ADDR_KEY0, ADDR_MSG0, ADDR_CT0, ADDR_CMD, ADDR_STATUS)
  - status bit indices
  - state enum typedef
- Sub-module aes_reg_word is one 32-bit word with async active-low reset, load, and independent per-lane enables. The block instantiates NWORDS copies; word 15 is built from FSM state instead.

## Test plan
- Write 32'hDEADBEEF to word 0 with be=1111, then be=0010 data 32'h00005500 → readback 32'hDEAD55EF; aes_key[127:96] matches.
- Start in IDLE → aes_start high for 1 cycle, status reads 32'h2. Core writes 8–11, core_done → status 32'h1, words 8–11 read back.
- In BUSY, host writes 32'h12345678 to word 4 → accepted without wait, word 4 unchanged. Start command ignored (no second aes_start).
- Host write and core_req together for 3 cycles → cycle 1 host, cycle 2 core with avl_waitrequest=1, cycle 3 host.
- Assert Reset_n low mid-BUSY → all outputs 0 immediately, status 0, no aes_start after release.
- Read word 2 after writing 32'hCAFEF00D → CAFEF00D with AES_KEY_READBACK_EN defined, 0 without.

Source files
------------

// File: rtl/aes_reg_pkg.sv
// aes_reg_pkg: shared constants and types for the AES register controller.
// Optional key readback is enabled by defining AES_KEY_READBACK_EN.
package aes_reg_pkg;

    localparam logic [3:0] ADDR_KEY0   = 4'd0;
    localparam logic [3:0] ADDR_MSG0   = 4'd4;
    localparam logic [3:0] ADDR_CT0    = 4'd8;
    localparam logic [3:0] ADDR_SCR0   = 4'd12;
    localparam logic [3:0] ADDR_CMD    = 4'd14;
    localparam logic [3:0] ADDR_STATUS = 4'd15;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

endpackage

// File: rtl/aes_reg_word.sv
// aes_reg_word: one 32-bit bank word with per-byte-lane write enables.
// Async active-low reset clears the word.
module aes_reg_word (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    always_comb begin
        word_d = word_q;
        if (load_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    word_d[8*b +: 8] = d_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q_o = word_q;

endmodule

// File: rtl/aes_reg_ctrl.sv
// aes_reg_ctrl: AES register bank, host/core write arbiter and run sequencer.
// Define AES_KEY_READBACK_EN to let the host read back key words 0-3.
module aes_reg_ctrl
    import aes_reg_pkg::*;
#(
    parameter int NWORDS    = 16,
    parameter int STALL_MAX = 1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         avl_cs,
    input  logic         avl_read,
    input  logic         avl_write,
    input  logic [3:0]   avl_addr,
    input  logic [3:0]   avl_byte_en,
    input  logic [31:0]  avl_writedata,
    output logic [31:0]  avl_readdata,
    output logic         avl_waitrequest,
    input  logic         core_req,
    input  logic [3:0]   core_addr,
    input  logic [3:0]   core_be,
    input  logic [31:0]  core_wdata,
    output logic         core_gnt,
    input  logic         core_done,
    output logic         aes_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_msg
);

    localparam int DW = $clog2(STALL_MAX + 2);

    state_e        state_q;
    logic [DW-1:0] deny_q;
    logic          start_q;
    logic [31:0]   rdata_q;

    logic [31:0]       words [NWORDS];
    logic [NWORDS-1:0] wr_en;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [31:0]       rd_mux;

    logic host_wr, conflict, core_pri, host_acc;
    logic cmd_wr, cmd_start, cmd_stop;
    logic host_ok, core_ok, busy, key_rd_ok;

`ifdef AES_KEY_READBACK_EN
    assign key_rd_ok = 1'b1;
`else
    assign key_rd_ok = 1'b0;
`endif

    // Host wins a conflict until the core has been denied STALL_MAX times.
    assign host_wr         = avl_cs & avl_write;
    assign conflict        = host_wr & core_req;
    assign core_pri        = conflict & (deny_q >= DW'(STALL_MAX));
    assign core_gnt        = core_req & (~conflict | core_pri);
    assign avl_waitrequest = core_pri;
    assign host_acc        = host_wr & ~core_pri;

    assign busy      = (state_q == S_BUSY);
    assign cmd_wr    = host_acc & (avl_addr == ADDR_CMD) & avl_byte_en[0];
    assign cmd_start = cmd_wr & avl_writedata[0];
    assign cmd_stop  = cmd_wr & ~avl_writedata[0];

    assign host_ok = (avl_addr < ADDR_CMD) & ~(busy & (avl_addr < ADDR_SCR0));
    assign core_ok = (core_addr >= ADDR_CT0) & (core_addr < ADDR_SCR0);

    always_comb begin
        wr_en   = '0;
        wr_be   = avl_byte_en;
        wr_data = avl_writedata;
        if (host_acc & host_ok) begin
            wr_en[avl_addr] = 1'b1;
        end else if (core_gnt & core_ok) begin
            wr_en[core_addr] = 1'b1;
            wr_be            = core_be;
            wr_data          = core_wdata;
        end
    end

    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        if (i < int'(ADDR_CMD)) begin : g_store
            aes_reg_word u_word (
                .clk_i  (Clk),
                .rst_ni (Reset_n),
                .load_i (wr_en[i]),
                .be_i   (wr_be),
                .d_i    (wr_data),
                .q_o    (words[i])
            );
        end else begin : g_none
            assign words[i] = '0;
        end
    end

    always_comb begin
        rd_mux = words[avl_addr];
        if (avl_addr == ADDR_STATUS) begin
            rd_mux          = '0;
            rd_mux[ST_BUSY] = busy;
            rd_mux[ST_DONE] = (state_q == S_DONE);
        end else if (avl_addr == ADDR_CMD) begin
            rd_mux = '0;
        end else if ((avl_addr < ADDR_MSG0) & ~key_rd_ok) begin
            rd_mux = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            deny_q  <= '0;
            rdata_q <= '0;
        end else begin
            start_q <= 1'b0;
            if (avl_cs & avl_read) begin
                rdata_q <= rd_mux;
            end
            if (core_gnt) begin
                deny_q <= '0;
            end else if (conflict) begin
                deny_q <= deny_q + DW'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_start) begin
                        state_q <= S_BUSY;
                        start_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (core_done) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (cmd_start) begin
                        state_q <= S_BUSY;
                        start_q <= 1'b1;
                    end else if (cmd_stop) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign avl_readdata = rdata_q;
    assign aes_start    = start_q;
    assign aes_key      = {words[ADDR_KEY0], words[ADDR_KEY0 + 4'd1],
                           words[ADDR_KEY0 + 4'd2], words[ADDR_KEY0 + 4'd3]};
    assign aes_msg      = {words[ADDR_MSG0], words[ADDR_MSG0 + 4'd1],
                           words[ADDR_MSG0 + 4'd2], words[ADDR_MSG0 + 4'd3]};

endmodule

// File: tb/tb_aes_reg_ctrl.sv
// tb_aes_reg_ctrl: directed and random checks of aes_reg_ctrl against
// a behavioural model of the register map, arbiter and run sequence.
module tb_aes_reg_ctrl;

    localparam int STALL_MAX = 1;
    localparam int IDLE = 0, BUSY = 1, DONE = 2;
`ifdef AES_KEY_READBACK_EN
    localparam bit KEY_RB = 1'b1;
`else
    localparam bit KEY_RB = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         avl_cs, avl_read, avl_write;
    logic [3:0]   avl_addr, avl_byte_en;
    logic [31:0]  avl_writedata;
    logic [31:0]  avl_readdata;
    logic         avl_waitrequest;
    logic         core_req;
    logic [3:0]   core_addr, core_be;
    logic [31:0]  core_wdata;
    logic         core_gnt;
    logic         core_done;
    logic         aes_start;
    logic [127:0] aes_key, aes_msg;

    always #5 Clk = ~Clk;

    aes_reg_ctrl #(.NWORDS(16), .STALL_MAX(STALL_MAX)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .avl_cs          (avl_cs),
        .avl_read        (avl_read),
        .avl_write       (avl_write),
        .avl_addr        (avl_addr),
        .avl_byte_en     (avl_byte_en),
        .avl_writedata   (avl_writedata),
        .avl_readdata    (avl_readdata),
        .avl_waitrequest (avl_waitrequest),
        .core_req        (core_req),
        .core_addr       (core_addr),
        .core_be         (core_be),
        .core_wdata      (core_wdata),
        .core_gnt        (core_gnt),
        .core_done       (core_done),
        .aes_start       (aes_start),
        .aes_key         (aes_key),
        .aes_msg         (aes_msg)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    int          st;
    int          deny;
    bit          start_exp;
    logic [31:0] rd_exp;
    bit          last_wait;
    bit          last_gnt;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                          logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] mread(int a);
        if (a == 15) return {30'd0, st == BUSY, st == DONE};
        if (a == 14) return 32'd0;
        if (a < 4 && !KEY_RB) return 32'd0;
        return mem[a];
    endfunction

    task automatic model_reset();
        foreach (mem[i]) mem[i] = 32'd0;
        st = IDLE;
        deny = 0;
        start_exp = 1'b0;
        rd_exp = 32'd0;
        last_wait = 1'b0;
        last_gnt = 1'b0;
    endtask

    task automatic clr_host();
        avl_cs = 0; avl_read = 0; avl_write = 0;
        avl_addr = 0; avl_byte_en = 0; avl_writedata = 0;
    endtask

    task automatic clr_core();
        core_req = 0; core_addr = 0; core_be = 0; core_wdata = 0;
        core_done = 0;
    endtask

    // One clock: entered at a negedge with inputs set, returns at the next negedge.
    task automatic cyc();
        bit hw, conf, cwin, gnt_e;
        int old, ha, ca;
        #1;
        hw    = avl_cs && avl_write;
        conf  = hw && core_req;
        cwin  = conf && (deny >= STALL_MAX);
        gnt_e = core_req && (!conf || cwin);
        chk("core_gnt", core_gnt, gnt_e);
        chk("waitrequest", avl_waitrequest, cwin);
        ha = avl_addr;
        ca = core_addr;
        old = st;
        start_exp = 1'b0;
        if (avl_cs && avl_read) rd_exp = mread(ha);
        if (hw && !cwin) begin
            if (ha < 14 && !(old == BUSY && ha < 12))
                mem[ha] = merge(mem[ha], avl_writedata, avl_byte_en);
            if (ha == 14 && avl_byte_en[0]) begin
                if (avl_writedata[0] && old != BUSY) begin
                    st = BUSY;
                    start_exp = 1'b1;
                end else if (!avl_writedata[0] && old == DONE) begin
                    st = IDLE;
                end
            end
        end
        if (gnt_e && ca >= 8 && ca <= 11)
            mem[ca] = merge(mem[ca], core_wdata, core_be);
        if (core_done && old == BUSY) st = DONE;
        if (gnt_e) deny = 0;
        else if (conf) deny = deny + 1;
        last_wait = cwin;
        last_gnt = gnt_e;
        @(posedge Clk);
        #1;
        chk("readdata", avl_readdata, rd_exp);
        chk("aes_start", aes_start, start_exp);
        chk("aes_key", aes_key, {mem[0], mem[1], mem[2], mem[3]});
        chk("aes_msg", aes_msg, {mem[4], mem[5], mem[6], mem[7]});
        @(negedge Clk);
    endtask

    task automatic hwr(logic [3:0] a, logic [3:0] be, logic [31:0] d);
        avl_cs = 1; avl_write = 1; avl_read = 0;
        avl_addr = a; avl_byte_en = be; avl_writedata = d;
        cyc();
        clr_host();
    endtask

    task automatic hrd(logic [3:0] a);
        avl_cs = 1; avl_read = 1; avl_write = 0; avl_addr = a;
        cyc();
        clr_host();
    endtask

    task automatic cwr(logic [3:0] a, logic [3:0] be, logic [31:0] d);
        core_req = 1; core_addr = a; core_be = be; core_wdata = d;
        cyc();
        clr_core();
    endtask

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_readdata"}, avl_readdata, 0);
        chk({tag, "_start"}, aes_start, 0);
        chk({tag, "_key"}, aes_key, 0);
        chk({tag, "_msg"}, aes_msg, 0);
        chk({tag, "_gnt"}, core_gnt, 0);
        chk({tag, "_wait"}, avl_waitrequest, 0);
    endtask

    initial begin
        logic [31:0] msg0, ad;
        logic [31:0] ct [4];
        logic [31:0] arb_d [3];

        Reset_n = 1'b1;
        clr_host();
        clr_core();
        model_reset();
        #1 Reset_n = 1'b0;
        #1 chk_zero_outputs("reset");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        hwr(4'd0, 4'b1111, 32'hDEADBEEF);
        hwr(4'd0, 4'b0010, 32'h00005500);
        chk("key0_lanes", aes_key[127:96], 32'hDEAD55EF);
        hrd(4'd0);
        chk("key0_read", avl_readdata, KEY_RB ? 32'hDEAD55EF : 32'h0);
        hwr(4'd2, 4'b1111, 32'hCAFEF00D);
        hrd(4'd2);
        chk("key2_read", avl_readdata, KEY_RB ? 32'hCAFEF00D : 32'h0);
        hwr(4'd12, 4'b1001, 32'h11223344);
        hrd(4'd12);
        chk("scratch_lanes", avl_readdata, 32'h11000044);
        hwr(4'd12, 4'b0000, 32'hFFFFFFFF);
        hrd(4'd12);
        chk("be_zero_noop", avl_readdata, 32'h11000044);
        hrd(4'd14);
        chk("cmd_reads_0", avl_readdata, 32'h0);

        msg0 = $urandom;
        hwr(4'd4, 4'b1111, msg0);
        for (int i = 5; i < 8; i++) hwr(4'(i), 4'b1111, $urandom);

        hwr(4'd14, 4'b0001, 32'h1);
        chk("start_pulse", aes_start, 1);
        hrd(4'd15);
        chk("status_busy", avl_readdata, 32'h2);

        hwr(4'd4, 4'b1111, 32'h12345678);
        chk("busy_drop_msg", aes_msg[127:96], msg0);
        hwr(4'd14, 4'b0001, 32'h1);
        chk("start_ignored", aes_start, 0);

        for (int i = 0; i < 4; i++) begin
            ct[i] = $urandom;
            cwr(4'(8 + i), 4'b1111, ct[i]);
        end
        cwr(4'd15, 4'b1111, 32'hFFFFFFFF);
        cwr(4'd3, 4'b1111, 32'h0BADBAD0);
        core_done = 1;
        cyc();
        core_done = 0;
        hrd(4'd15);
        chk("status_done", avl_readdata, 32'h1);
        for (int i = 0; i < 4; i++) begin
            hrd(4'(8 + i));
            chk("ct_read", avl_readdata, ct[i]);
        end

        for (int k = 0; k < 3; k++) begin
            arb_d[k] = $urandom;
            avl_cs = 1; avl_write = 1; avl_addr = 4'd13;
            avl_byte_en = 4'b1111; avl_writedata = 32'hA5A5A5A5;
            core_req = 1; core_be = 4'b1111; core_wdata = arb_d[k];
            core_addr = (k < 2) ? 4'd9 : 4'd10;
            #1;
            chk("arb_gnt", core_gnt, k == 1);
            chk("arb_wait", avl_waitrequest, k == 1);
            cyc();
        end
        clr_host();
        clr_core();
        hrd(4'd13);
        chk("arb_host_word", avl_readdata, 32'hA5A5A5A5);
        hrd(4'd9);
        chk("arb_core_word", avl_readdata, arb_d[1]);
        hrd(4'd10);
        chk("arb_denied_word", avl_readdata, ct[2]);

        hwr(4'd14, 4'b0001, 32'h1);
        chk("restart_pulse", aes_start, 1);
        core_done = 1;
        cyc();
        core_done = 0;
        hwr(4'd14, 4'b0001, 32'h0);
        hrd(4'd15);
        chk("status_idle", avl_readdata, 32'h0);
        hwr(4'd14, 4'b0001, 32'h1);
        hrd(4'd11);

        #2 Reset_n = 1'b0;
        #1 chk_zero_outputs("midrun_reset");
        model_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
        hrd(4'd15);
        chk("status_after_reset", avl_readdata, 32'h0);
        repeat (3) cyc();

        for (int n = 0; n < 400; n++) begin
            if (!last_wait) begin
                int op;
                op = $urandom_range(0, 3);
                avl_cs = (op != 0);
                avl_read = (op == 1 || op == 3);
                avl_write = (op >= 2);
                ad = $urandom;
                avl_addr = ($urandom_range(0, 5) == 0) ? 4'd14 : ad[3:0];
                avl_byte_en = 4'($urandom);
                avl_writedata = $urandom;
            end
            if (!core_req || last_gnt) begin
                core_req = ($urandom_range(0, 2) == 0);
                ad = $urandom;
                core_addr = ($urandom_range(0, 3) == 0) ? ad[3:0]
                                                        : 4'(8 + ad[1:0]);
                core_be = 4'($urandom);
                core_wdata = $urandom;
            end
            core_done = ($urandom_range(0, 7) == 0);
            cyc();
        end
        clr_host();
        clr_core();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
